// File: rtl/alu_issue_ctrl.sv
// Issue sequencer in front of TotalALU: accepts one operation, holds the ALU inputs
// for the required cycles, runs MFHI/MFLO after MULTU and returns results over valid/ready.
module alu_issue_ctrl #(
  parameter int MUL_WAIT   = 35,
  parameter int RES_LAT    = 1,
  parameter int IDLE_FUNCT = 36
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_funct,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic [31:0] alu_dataA,
  output logic [31:0] alu_dataB,
  output logic [5:0]  alu_signal,
  input  logic [31:0] alu_output,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic [5:0]  res_funct,
  output logic        busy,
  output logic        illegal
);

  typedef enum logic [2:0] {
    S_IDLE, S_EXEC, S_MUL, S_MFHI, S_RESP_HI, S_MFLO, S_RESP
  } state_t;

  localparam logic [5:0] F_IDLE  = 6'(IDLE_FUNCT);
  localparam logic [5:0] F_MULTU = 6'd25;
  localparam logic [5:0] F_MFHI  = 6'd16;
  localparam logic [5:0] F_MFLO  = 6'd18;
  localparam logic [5:0] LAT     = 6'(RES_LAT);
  localparam logic [5:0] WAIT    = 6'(MUL_WAIT);

  function automatic logic is_single(input logic [5:0] f);
    case (f)
      6'd0, 6'd32, 6'd34, 6'd36, 6'd37, 6'd42: is_single = 1'b1;
      default:                                 is_single = 1'b0;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] data_a_q, data_a_d, data_b_q, data_b_d;
  logic [5:0]  signal_q, signal_d;
  logic        res_valid_q, res_valid_d;
  logic [31:0] res_data_q, res_data_d;
  logic [5:0]  res_funct_q, res_funct_d;
  logic        in_ready_q, in_ready_d;
  logic        busy_q, busy_d;
  logic        illegal_q, illegal_d;

  // Next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    data_a_d    = data_a_q;
    data_b_d    = data_b_q;
    signal_d    = signal_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_funct_d = res_funct_q;
    illegal_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          if (is_single(in_funct)) begin
            data_a_d = in_a;
            data_b_d = in_b;
            signal_d = in_funct;
            cnt_d    = LAT;
            state_d  = S_EXEC;
          end else if (in_funct == F_MULTU) begin
            data_a_d = in_a;
            data_b_d = in_b;
            signal_d = F_MULTU;
            cnt_d    = WAIT;
            state_d  = S_MUL;
          end else begin
            illegal_d = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      // alu_signal already holds the funct (or 16/18), so it doubles as res_funct.
      S_EXEC, S_MFHI, S_MFLO: begin
        if (cnt_q == 6'd0) begin
          res_data_d  = alu_output;
          res_funct_d = signal_q;
          res_valid_d = 1'b1;
          state_d     = (state_q == S_MFHI) ? S_RESP_HI : S_RESP;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
      S_MUL: begin
        if (cnt_q == 6'd1) begin
          signal_d = F_MFHI;
          cnt_d    = LAT;
          state_d  = S_MFHI;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
      S_RESP_HI: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          signal_d    = F_MFLO;
          cnt_d       = LAT;
          state_d     = S_MFLO;
        end else begin
          state_d = S_RESP_HI;
        end
      end
      S_RESP: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          data_a_d    = 32'd0;
          data_b_d    = 32'd0;
          signal_d    = F_IDLE;
          state_d     = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d = (state_d == S_IDLE);
    busy_d     = (state_d != S_IDLE);
  end

  // State and output registers; in_ready stays low until the first edge after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 6'd0;
      data_a_q    <= 32'd0;
      data_b_q    <= 32'd0;
      signal_q    <= F_IDLE;
      res_valid_q <= 1'b0;
      res_data_q  <= 32'd0;
      res_funct_q <= 6'd0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      data_a_q    <= data_a_d;
      data_b_q    <= data_b_d;
      signal_q    <= signal_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_funct_q <= res_funct_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      illegal_q   <= illegal_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign alu_dataA  = data_a_q;
  assign alu_dataB  = data_b_q;
  assign alu_signal = signal_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign res_funct  = res_funct_q;
  assign busy       = busy_q;
  assign illegal    = illegal_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: TotalALU stand-in, transaction-level result model and
// directed scenarios with hand-computed expectations.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_funct;
  logic [31:0] in_a, in_b;
  logic [31:0] alu_dataA, alu_dataB;
  logic [5:0]  alu_signal;
  logic [31:0] alu_output;
  logic        res_valid, res_ready;
  logic [31:0] res_data;
  logic [5:0]  res_funct;
  logic        busy, illegal;

  int checks = 0;
  int errors = 0;

  alu_issue_ctrl dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_funct(in_funct), .in_a(in_a), .in_b(in_b),
    .alu_dataA(alu_dataA), .alu_dataB(alu_dataB), .alu_signal(alu_signal),
    .alu_output(alu_output), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_funct(res_funct), .busy(busy), .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] op_fn(input logic [5:0] f, input logic [31:0] a,
                                        input logic [31:0] b);
    case (f)
      6'd0:    op_fn = b << a[4:0];
      6'd32:   op_fn = a + b;
      6'd34:   op_fn = a - b;
      6'd36:   op_fn = a & b;
      6'd37:   op_fn = a | b;
      6'd42:   op_fn = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: op_fn = 32'd0;
    endcase
  endfunction

  function automatic logic known_op(input logic [5:0] f);
    case (f)
      6'd0, 6'd25, 6'd32, 6'd34, 6'd36, 6'd37, 6'd42: known_op = 1'b1;
      default:                                        known_op = 1'b0;
    endcase
  endfunction

  // TotalALU stand-in: one cycle output latency, Hi/Lo written while Signal=25.
  logic [31:0] hi_r, lo_r;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_output <= 32'd0;
      hi_r       <= 32'd0;
      lo_r       <= 32'd0;
    end else begin
      case (alu_signal)
        6'd25: begin
          {hi_r, lo_r} <= {32'd0, alu_dataA} * {32'd0, alu_dataB};
          alu_output   <= 32'd0;
        end
        6'd16:   alu_output <= hi_r;
        6'd18:   alu_output <= lo_r;
        default: alu_output <= op_fn(alu_signal, alu_dataA, alu_dataB);
      endcase
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  logic [37:0] exp_q[$];
  logic [31:0] seen_q[$];
  logic        prev_rst = 1'b1, prev_in_ready = 1'b0, prev_res_valid = 1'b0;
  logic [31:0] prev_res_data = 32'd0;
  logic [5:0]  prev_res_funct = 6'd0;

  // Advance one cycle and compare the DUT against the transaction model.
  task automatic tick();
    logic        acc, xfer;
    logic [37:0] e;
    logic [63:0] p;
    @(negedge clk);
    if (reset) begin
      chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_alu_signal", {26'd0, alu_signal}, 32'd36);
      chk("rst_res_data", res_data, 32'd0);
      exp_q.delete();
      prev_rst = 1'b1;
      prev_in_ready = 1'b0;
      prev_res_valid = 1'b0;
    end else begin
      acc  = prev_in_ready && in_valid;
      xfer = prev_res_valid && res_ready;
      if (xfer) begin
        seen_q.push_back(prev_res_data);
        chk("res_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("res_data", prev_res_data, e[31:0]);
          chk("res_funct", {26'd0, prev_res_funct}, {26'd0, e[37:32]});
        end
      end else if (prev_res_valid) begin
        chk("hold_valid", {31'd0, res_valid}, 32'd1);
        chk("hold_data", res_data, prev_res_data);
        chk("hold_funct", {26'd0, res_funct}, {26'd0, prev_res_funct});
      end
      chk("illegal", {31'd0, illegal}, {31'd0, acc && !known_op(in_funct)});
      if (acc && in_funct == 6'd25) begin
        p = {32'd0, in_a} * {32'd0, in_b};
        exp_q.push_back({6'd16, p[63:32]});
        exp_q.push_back({6'd18, p[31:0]});
      end else if (acc && known_op(in_funct)) begin
        exp_q.push_back({in_funct, op_fn(in_funct, in_a, in_b)});
      end
      if (!prev_rst) chk("busy_vs_ready", {31'd0, busy}, {31'd0, !in_ready});
      prev_rst       = 1'b0;
      prev_in_ready  = in_ready;
      prev_res_valid = res_valid;
      prev_res_data  = res_data;
      prev_res_funct = res_funct;
    end
  endtask

  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1;
    in_funct = f;
    in_a     = a;
    in_b     = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 100 && !res_valid; i++) tick();
    chk("wait_res_valid", {31'd0, res_valid}, 32'd1);
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n, nb;
    reset = 1'b1; in_valid = 1'b0; in_funct = 6'd0; in_a = 32'd0; in_b = 32'd0;
    res_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("ready_after_reset", {31'd0, in_ready}, 32'd1);

    // ADD 5,7 with res_ready raised early
    res_ready = 1'b1;
    tick();
    chk("early_ready_no_valid", {31'd0, res_valid}, 32'd0);
    res_ready = 1'b0;
    issue(6'd32, 32'd5, 32'd7);
    chk("add_signal", {26'd0, alu_signal}, 32'd32);
    chk("add_dataA", alu_dataA, 32'd5);
    chk("add_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    chk("add_valid_e1", {31'd0, res_valid}, 32'd0);
    tick();
    chk("add_valid_e2", {31'd0, res_valid}, 32'd1);
    chk("add_data", res_data, 32'd12);
    chk("add_funct", {26'd0, res_funct}, 32'd32);
    handshake();
    chk("add_ready_after", {31'd0, in_ready}, 32'd1);
    chk("add_signal_idle", {26'd0, alu_signal}, 32'd36);

    // MULTU 100000 x 300000
    issue(6'd25, 32'd100000, 32'd300000);
    n = 0; nb = 0;
    while (alu_signal == 6'd25 && n < 100) begin
      n++;
      nb += (busy ? 0 : 1);
      tick();
    end
    chk("mul_hold_cycles", 32'(n), 32'd35);
    chk("mfhi_signal", {26'd0, alu_signal}, 32'd16);
    wait_valid();
    chk("hi_data", res_data, 32'd6);
    chk("hi_funct", {26'd0, res_funct}, 32'd16);
    nb += (busy ? 0 : 1);
    handshake();
    chk("mflo_signal", {26'd0, alu_signal}, 32'd18);
    nb += (busy ? 0 : 1);
    wait_valid();
    chk("lo_data", res_data, 32'd4230196224);
    chk("lo_funct", {26'd0, res_funct}, 32'd18);
    chk("mul_busy_low_cycles", 32'(nb), 32'd0);
    handshake();

    // SUB 3,5 held while an ADD request is offered
    issue(6'd34, 32'd3, 32'd5);
    wait_valid();
    in_valid = 1'b1; in_funct = 6'd32; in_a = 32'd1; in_b = 32'd1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("sub_hold_data", res_data, 32'hFFFF_FFFE);
      chk("sub_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    handshake();
    chk("sub_idle_ready", {31'd0, in_ready}, 32'd1);
    chk("sub_idle_busy", {31'd0, busy}, 32'd0);
    tick(); tick(); tick();
    chk("no_ghost_add", {31'd0, res_valid}, 32'd0);

    // illegal funct 7
    issue(6'd7, 32'd9, 32'd9);
    chk("illegal_pulse", {31'd0, illegal}, 32'd1);
    chk("illegal_ready", {31'd0, in_ready}, 32'd1);
    chk("illegal_signal", {26'd0, alu_signal}, 32'd36);
    tick();
    chk("illegal_one_cycle", {31'd0, illegal}, 32'd0);
    chk("illegal_no_res", {31'd0, res_valid}, 32'd0);
    chk("illegal_dataA", alu_dataA, 32'd0);

    // reset during the 10th MUL cycle, then SLT
    issue(6'd25, 32'd2, 32'd3);
    for (int i = 0; i < 9; i++) tick();
    chk("mul10_signal", {26'd0, alu_signal}, 32'd25);
    reset = 1'b1;
    #1;
    chk("async_rst_signal", {26'd0, alu_signal}, 32'd36);
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_ready", {31'd0, in_ready}, 32'd0);
    chk("async_rst_dataA", alu_dataA, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("ready_after_rst2", {31'd0, in_ready}, 32'd1);
    issue(6'd42, 32'hFFFF_FFFF, 32'd1);
    wait_valid();
    chk("slt_data", res_data, 32'd1);
    handshake();

    // back-to-back AND then OR with res_ready tied high
    seen_q.delete();
    res_ready = 1'b1;
    issue(6'd36, 32'h0000_F0F0, 32'h0000_FF00);
    in_valid = 1'b1; in_funct = 6'd37; in_a = 32'h0000_F0F0; in_b = 32'h0000_0F0F;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    chk("b2b_ready_gap", 32'(n), 32'd3);
    tick();
    in_valid = 1'b0;
    chk("b2b_or_accepted", {26'd0, alu_signal}, 32'd37);
    chk("b2b_or_busy", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 6; i++) tick();
    res_ready = 1'b0;
    chk("b2b_count", 32'(seen_q.size()), 32'd2);
    if (seen_q.size() == 2) begin
      chk("b2b_and", seen_q[0], 32'h0000_F000);
      chk("b2b_or", seen_q[1], 32'h0000_FFFF);
    end
    chk("model_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Issue sequencer that sits directly upstream of TotalALU and drives its dataA/dataB/Signal inputs.
- Accepts one operation at a time over a valid/ready handshake.
- Holds Signal and operands stable for the required number of cycles.
- For MULTU, waits out the multiplier and then issues MFHI and MFLO itself.
- Returns every ALU result over a valid/ready result port.

Parameters:
MUL_WAIT, 35, number of cycles Signal is held at 25 (MULTU) before MFHI is issued.
RES_LAT, 1, ALU output latency in cycles after Signal/operands are applied.
IDLE_FUNCT, 36, funct driven to the ALU when no operation is active (AND, with operands 0).

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
in_valid  in  1  operation request
in_ready  out  1  controller can accept an operation
in_funct  in  6  funct: 0 SLL, 25 MULTU, 32 ADD, 34 SUB, 36 AND, 37 OR, 42 SLT
in_a  in  32  operand A
in_b  in  32  operand B
alu_dataA  out  32  to TotalALU dataA
alu_dataB  out  32  to TotalALU dataB
alu_signal  out  6  to TotalALU Signal
alu_output  in  32  from TotalALU Output
res_valid  out  1  result available
res_ready  in  1  result consumer ready
res_data  out  32  captured ALU result
res_funct  out  6  funct that produced res_data (16 for Hi, 18 for Lo)
busy  out  1  state != IDLE
illegal  out  1  one-cycle pulse on rejected funct

Behaviour:
- Reset (asynchronous, takes effect immediately regardless of state):
  - state=IDLE; alu_dataA=alu_dataB=0; alu_signal=IDLE_FUNCT.
  - res_valid=0, res_data=0, res_funct=0, illegal=0, counters=0.
  - in_ready=0 while reset is high; in_ready=1 in the first cycle after release.
- in_ready = (state==IDLE). Operations are accepted only when in_valid&&in_ready at a rising edge (edge E0). A sampled in_valid with in_ready=0 is ignored; no queueing.
- All alu_* outputs are registered and stay stable for the whole active phase.
- States:
  - IDLE: on accept, latch in_a/in_b/in_funct into the alu_* registers.
    - funct in {0,32,34,36,37,42}: go to EXEC.
    - funct 25: go to MUL, load counter with MUL_WAIT.
    - any other funct: assert illegal for 1 cycle, remain IDLE, alu_* unchanged at IDLE values, no result produced.
  - EXEC: lasts RES_LAT+1 cycles. At the last edge (E0+RES_LAT+1), capture alu_output into res_data and in_funct into res_funct, set res_valid=1, go to RESP.
  - MUL: alu_signal held at 25. Counter decrements once per cycle. When it reaches 0, go to MFHI with alu_signal=16.
  - MFHI: lasts RES_LAT+1 cycles, then capture res_data (Hi), res_funct=16, res_valid=1, go to RESP_HI.
  - RESP_HI: hold until res_ready; then res_valid=0, alu_signal=18, go to MFLO.
  - MFLO: same timing as MFHI; capture Lo, res_funct=18, go to RESP.
  - RESP: hold until res_ready; then res_valid=0, alu_dataA/alu_dataB=0, alu_signal=IDLE_FUNCT, go to IDLE.
- Result port rules:
  - res_data and res_funct are stable while res_valid=1 and res_ready=0.
  - A transfer happens on the edge where res_valid&&res_ready.
  - res_ready asserted early (before res_valid) has no effect.
- Throughput:
  - Non-MULTU operations: minimum RES_LAT+3 cycles per operation (accept, EXEC, RESP).
  - MULTU: MUL_WAIT + 2*(RES_LAT+1) + 2 handshake cycles minimum.
- No arithmetic is performed here. Widths pass through unchanged, and all result data comes from alu_output.
- Counter is 6 bits wide; MUL_WAIT must be between 1 and 63.
- Reset asserted during MUL leaves the ALU multiplier state to TotalALU's own reset, which shares this reset.

Test Plan:
- ADD 5,7 accepted at edge E0 -> alu_signal=32 from E0; res_valid=1 after edge E0+2 with res_data=12, res_funct=32; in_ready=1 one cycle after the handshake.
- MULTU 100000,300000 -> alu_signal=25 for exactly 35 cycles, then 16; Hi result res_data=6 with res_funct=16; after the handshake, alu_signal=18; Lo result res_data=4230196224 with res_funct=18; busy=1 throughout.
- SUB 3,5 with res_ready held low for 5 cycles -> res_data=0xFFFFFFFE stable; in_ready=0; a concurrent in_valid with ADD is ignored; IDLE is reached 1 cycle after res_ready rises.
- in_funct=7 -> illegal=1 for exactly one cycle; res_valid stays 0; alu_signal stays 36; in_ready stays 1.
- reset pulsed during the 10th MUL cycle -> all outputs return to reset values immediately; a following SLT 0xFFFFFFFF,1 yields res_data=1.
- Back-to-back AND 0xF0F0,0xFF00 then OR 0xF0F0,0x0F0F with res_ready tied high -> 0xF000, then 0xFFFF; the second operation is accepted on the first cycle in_ready returns to 1.
